fetch_sequencer: RTL and testbench

- Controller that sequences the PC register and instruction fetch for the core.
- Drives PC_NEXT into the PC register. It holds PC by feeding back the current value, loads the reset vector, or advances by +4 or to a branch target.
- Runs a req/ack handshake with instruction memory and hands each fetched instruction to the execute logic. It waits for execute to retire that instruction before advancing.
- A wait-state timeout and a misaligned-target check drive a sticky fault state.

---
 rtl/fetch_sequencer.sv | 85 ++++++++
 tb/tb_fetch_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// PC sequencing and instruction fetch controller: boots to RESET_VECTOR,
// fetches over a req/ack handshake, waits for execute to retire, then advances.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] PC_NEXT,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fault
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, FAULT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      wait_cnt    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      // Flag marks only the first EXEC cycle after a completed fetch.
      instr_valid <= (state == FETCH) && imem_ack;
      if (state == FETCH) begin
        if (imem_ack) begin
          instr    <= imem_rdata;
          wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LAST) begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    PC_NEXT    = PC;
    case (state)
      BOOT: begin
        PC_NEXT    = RESET_VECTOR;
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack)                   state_next = EXEC;
        else if (wait_cnt == WAIT_LAST) state_next = FAULT;
      end
      EXEC: begin
        if (exec_done) begin
          if (!branch_taken) begin
            PC_NEXT    = PC + 32'd4;
            state_next = FETCH;
          end else if (branch_target[1:0] == 2'b00) begin
            PC_NEXT    = branch_target;
            state_next = FETCH;
          end else begin
            state_next = FAULT;
          end
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = PC;
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an external PC register model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pc_next, imem_addr, imem_rdata, instr, branch_target;
  logic        imem_req, imem_ack, instr_valid, exec_done, branch_taken, fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // PC register: loads PC_NEXT on every rising edge.
  always @(posedge clk) pc <= pc_next;

  fetch_sequencer #(
    .RESET_VECTOR(32'h0000_0100),
    .MAX_WAIT    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (pc),
    .PC_NEXT      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .fault        (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first FETCH cycle; ack immediately, retire together with
  // instr_valid, and land in the next FETCH cycle.
  task automatic run_instr(input logic [31:0] word, input logic br,
                           input logic [31:0] tgt, input logic [31:0] exp_next);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    check("ri_valid", instr_valid, 1);
    check("ri_instr", instr, word);
    check("ri_req_exec", imem_req, 0);
    exec_done     = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    check("ri_pc_next", pc_next, exp_next);
    tick();
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    check("ri_valid_drop", instr_valid, 0);
    check("ri_req", imem_req, 1);
    check("ri_addr", imem_addr, exp_next);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = '0;

    repeat (3) tick();
    check("rst_req", imem_req, 0);
    check("rst_fault", fault, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc_next", pc_next, 32'h100);

    rst = 1'b0;
    #1;
    check("boot_pc_next", pc_next, 32'h100);
    check("boot_req", imem_req, 0);
    tick();
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, 32'h100);

    run_instr(32'h0050_0093, 1'b0, '0, 32'h104);
    run_instr(32'h00a0_0113, 1'b0, '0, 32'h108);

    // Stall in EXEC at 0x108 for ten cycles, then branch to 0x40.
    imem_ack = 1'b1; imem_rdata = 32'h0020_81b3;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_valid", instr_valid, (i == 0) ? 32'd1 : 32'd0);
      check("stall_instr", instr, 32'h0020_81b3);
      check("stall_pc_next", pc_next, 32'h108);
      tick();
    end
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    check("br_pc_next", pc_next, 32'h40);
    tick();
    exec_done = 1'b0; branch_taken = 1'b0;
    check("br_addr", imem_addr, 32'h40);

    // Ack on the fourth FETCH cycle still wins over the timeout.
    for (int i = 0; i < 3; i++) begin
      check("ws_req", imem_req, 1);
      tick();
    end
    check("ws_req4", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    check("ws_valid", instr_valid, 1);
    check("ws_instr", instr, 32'h1111_1111);
    check("ws_fault", fault, 0);
    exec_done = 1'b1;
    #1;
    check("ws_pc_next", pc_next, 32'h44);
    tick();
    exec_done = 1'b0;

    // No ack for four FETCH cycles -> sticky fault.
    for (int i = 0; i < 4; i++) begin
      check("to_req", imem_req, 1);
      check("to_fault", fault, 0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0]; exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
      #1;
      check("flt_fault", fault, 1);
      check("flt_req", imem_req, 0);
      check("flt_valid", instr_valid, 0);
      check("flt_pc_next", pc_next, 32'h44);
      tick();
    end
    imem_ack = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;

    // Asynchronous reset out of FAULT, then mid-FETCH with a stray ack.
    #2 rst = 1'b1;
    #1;
    check("arst_fault", fault, 0);
    check("arst_pc_next", pc_next, 32'h100);
    tick();
    rst = 1'b0;
    tick();
    check("mid_req_before", imem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_req", imem_req, 0);
    check("mid_fault", fault, 0);
    check("mid_pc_next", pc_next, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    check("stray_instr", instr, 0);
    check("stray_valid", instr_valid, 0);
    check("restart_addr", imem_addr, 32'h100);
    tick();
    check("restart_req", imem_req, 1);
    check("restart_addr2", imem_addr, 32'h100);

    run_instr(32'haaaa_0001, 1'b1, 32'hffff_fffc, 32'hffff_fffc);
    run_instr(32'haaaa_0002, 1'b0, '0, 32'h0);
    run_instr(32'haaaa_0003, 1'b1, 32'h108, 32'h108);

    // Misaligned branch target at PC=0x108.
    imem_ack = 1'b1; imem_rdata = 32'hbbbb_0004;
    tick();
    imem_ack = 1'b0;
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 32'h42;
    #1;
    check("mis_pc_next", pc_next, 32'h108);
    tick();
    exec_done = 1'b0; branch_taken = 1'b0;
    check("mis_fault", fault, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis_pc", pc, 32'h108);
      check("mis_req", imem_req, 0);
      check("mis_fault_sticky", fault, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
